video_pattern_gen: RTL and testbench
====================================

# video_pattern_gen

Upstream video source for the pixel-stream filters. It generates a complete raster with data-valid, horizontal sync and vertical sync, plus one of four test patterns. The output is the same 24-bit RGB + dv/hs/vs stream that the convolution filter accepts on its rx side. It drives filter inputs on the bench and on hardware when no HDMI receiver is attached, and it is the transmitter end of that pixel interface.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch, in pixels
- H_SYNC, 40, hs pulse width, in pixels
- H_BP, 220, horizontal back porch, in pixels
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch, in lines
- V_SYNC, 5, vs pulse width, in lines
- V_BP, 20, vertical back porch, in lines

Ports:
- clk  in  1  pixel clock
- rst  in  1  reset, asynchronous, active-low
- mode  in  2  pattern select, sampled at frame start
- tx_red  out  8  red component
- tx_green  out  8  green component
- tx_blue  out  8  blue component
- tx_dv  out  1  data valid, high on active pixels
- tx_hs  out  1  horizontal sync, active-high
- tx_vs  out  1  vertical sync, active-high
- frame_cnt  out  8  completed-frame counter, wraps at 255→0

## Operation
- Line and frame lengths: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Horizontal counter h:
  - Counts 0..H_TOTAL-1, then wraps to 0.
  - On each wrap, vertical counter v advances, counting 0..V_TOTAL-1 and then wrapping to 0.
- Frame start is h=0, v=0.
- Active region: h<H_ACTIVE and v<V_ACTIVE.
  - dv = active.
- Horizontal sync: hs = (H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC), evaluated on every line including blanking lines.
- Vertical sync: vs = (V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC), held for whole lines.
- Pattern mode:
  - mode is latched into mode_q only when the counters are at frame start.
  - A change of mode mid-frame takes effect on the next frame.
  - The pattern never tears within a frame.
- Patterns, evaluated on active pixels only. RGB is forced to 0 whenever dv=0.
  - 0, colour bars: 8 equal bars, BAR_W = H_ACTIVE/8 (integer division; the remainder columns belong to the last bar).
    - A bar counter advances every BAR_W pixels, which avoids a runtime divider.
    - Bar colours in order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - 1, grey ramp: R=G=B=h[7:0].
  - 2, checkerboard 16×16: FFFFFF when h[4]^v[4]=1, else 000000.
  - 3, scrolling bar: FFFFFF when h[10:4]==frame_cnt[6:0], else 000000. The bar moves 16 pixels per frame.
- frame_cnt increments by 1 in the cycle where h=H_TOTAL-1 and v=V_TOTAL-1.
- Reset while rst is low:
  - h, v, the bar counter and frame_cnt are 0; mode_q = 0.
  - All outputs are 0: RGB=000000, dv=hs=vs=0, frame_cnt=0.
  - Reset asserted mid-frame aborts the frame immediately, with no completion of the current line.

## Timing
- All outputs are registered. The outputs in cycle k reflect the counter state in cycle k-1 (latency 1).
- First rising edge after rst deasserts: the counters advance to h=1 and the outputs present pixel (h=0, v=0).
  - The first dv=1 therefore appears one cycle after release.
- Colour, dv, hs and vs are mutually aligned. No output changes except on the clk rising edge, apart from the asynchronous reset.
- mode setup: the value present in the cycle where h=0, v=0 is counted. The first pixel of that frame, output one cycle later, already uses the new pattern.
- Parameters are legal when every porch and sync value is ≥1 and H_ACTIVE ≥ 8; the counters are sized $clog2(H_TOTAL) and $clog2(V_TOTAL).
- Mode 3 uses h[10]. When H_TOTAL < 1024 the missing bits read as 0.

## Structure
- Shared package video_pkg:
  - pattern mode encodings PAT_BARS/PAT_RAMP/PAT_CHECK/PAT_SCROLL.
  - the 8-entry bar colour constant array.
- Sub-module video_timing_counter:
  - Contains the h/v counters and the raw active/hs/vs/frame-start/frame-end flags.
  - It is reusable by the future stream sink/checker.
- The top module holds the mode latch, the bar counter, frame_cnt, pattern generation and the output registers.

## Test plan
Bench parameters: H 16/2/2/4 (H_TOTAL 24) and V 4/1/1/2 (V_TOTAL 8).
- Reset release, mode=0 → tx_dv first high 1 cycle after release. dv high for 16 consecutive cycles per line, 4 lines per frame. Frame period 192 cycles.
- Sync placement → hs high exactly at line cycles 18–19. vs high for all 24 cycles of line 5. dv=0 throughout vs.
- Mode 0 with H_ACTIVE=16 (BAR_W=2) → pixel pairs are FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000. RGB=0 in blanking.
- Switch mode 0→1 at line 2 → the rest of that frame stays bars. The next frame's line 0 reads ramp 00..0F on each channel.
- frame_cnt → 0 after reset, increments once per 192 cycles. It reaches 255 and then wraps to 0 after 256 frames. In mode 3, the bar is white at columns 0–15 when frame_cnt=0 and at columns 16–31 when frame_cnt=1.
- Assert rst mid-line (h=7, v=2) for 3 cycles → all outputs are 0 immediately, asynchronously. After release, timing restarts from pixel (0,0) and mode_q is 0.

Source files
------------

// File: rtl/video_pkg.sv
// Shared definitions for the pixel-stream video blocks: pattern encodings,
// the RGB payload and the colour-bar palette.
package video_pkg;

    typedef enum logic [1:0] {
        PAT_BARS   = 2'd0,
        PAT_RAMP   = 2'd1,
        PAT_CHECK  = 2'd2,
        PAT_SCROLL = 2'd3
    } pat_e;

    typedef struct packed {
        logic [7:0] red;
        logic [7:0] green;
        logic [7:0] blue;
    } rgb_t;

    localparam int unsigned NUM_BARS = 8;
    localparam rgb_t        RGB_WHITE = 24'hFFFFFF;
    localparam rgb_t        RGB_BLACK = 24'h000000;

    // Index 0 is the leftmost bar (white), index 7 the rightmost (black).
    localparam rgb_t [NUM_BARS-1:0] BAR_COLORS = {
        24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
        24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
    };

endpackage

// File: rtl/video_timing_counter.sv
// Raster h/v counters with raw (combinational) active, sync and frame markers.
// Shared by the pattern generator and stream checkers.
module video_timing_counter
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20,
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
    localparam int unsigned HW      = $clog2(H_TOTAL),
    localparam int unsigned VW      = $clog2(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst,
    output logic [HW-1:0] h,
    output logic [VW-1:0] v,
    output logic          active_c,
    output logic          hs_c,
    output logic          vs_c,
    output logic          line_end_c,
    output logic          frame_start_c,
    output logic          frame_end_c
);

    logic last_line;

    assign line_end_c    = (h == HW'(H_TOTAL - 1));
    assign last_line     = (v == VW'(V_TOTAL - 1));
    assign frame_start_c = (h == '0) && (v == '0);
    assign frame_end_c   = line_end_c && last_line;
    assign active_c      = (h < HW'(H_ACTIVE)) && (v < VW'(V_ACTIVE));
    assign hs_c          = (h >= HW'(H_ACTIVE + H_FP)) && (h < HW'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_c          = (v >= VW'(V_ACTIVE + V_FP)) && (v < VW'(V_ACTIVE + V_FP + V_SYNC));

    // Line counter wraps every H_TOTAL pixels and steps the frame counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            h <= '0;
            v <= '0;
        end else if (line_end_c) begin
            h <= '0;
            v <= last_line ? '0 : v + VW'(1);
        end else begin
            h <= h + HW'(1);
        end
    end

endmodule

// File: rtl/video_pattern_gen.sv
// Test-pattern video source: full raster with dv/hs/vs and four selectable
// patterns; all outputs registered one cycle behind the counters.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 1280,
    parameter int unsigned H_FP     = 110,
    parameter int unsigned H_SYNC   = 40,
    parameter int unsigned H_BP     = 220,
    parameter int unsigned V_ACTIVE = 720,
    parameter int unsigned V_FP     = 5,
    parameter int unsigned V_SYNC   = 5,
    parameter int unsigned V_BP     = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] mode,
    output logic [7:0] tx_red,
    output logic [7:0] tx_green,
    output logic [7:0] tx_blue,
    output logic       tx_dv,
    output logic       tx_hs,
    output logic       tx_vs,
    output logic [7:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned BAR_W   = H_ACTIVE / NUM_BARS;
    localparam int unsigned BPW     = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    logic [HW-1:0]  h;
    logic [VW-1:0]  v;
    logic           active_c;
    logic           hs_c;
    logic           vs_c;
    logic           line_end_c;
    logic           frame_start_c;
    logic           frame_end_c;

    pat_e           mode_q;
    pat_e           mode_eff_c;
    logic [2:0]     bar_cnt;
    logic [BPW-1:0] bar_pix;
    rgb_t           pix_c;
    logic [6:0]     h_col_c;
    logic           v_b4_c;

    video_timing_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk           (clk),
        .rst           (rst),
        .h             (h),
        .v             (v),
        .active_c      (active_c),
        .hs_c          (hs_c),
        .vs_c          (vs_c),
        .line_end_c    (line_end_c),
        .frame_start_c (frame_start_c),
        .frame_end_c   (frame_end_c)
    );

    // Counter bits above the counter width read as zero.
    assign h_col_c = 7'(32'(h) >> 4);
    assign v_b4_c  = 1'(32'(v) >> 4);

    // Bar index tracks h without a divider; the last bar absorbs the remainder.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bar_cnt <= '0;
            bar_pix <= '0;
        end else if (line_end_c) begin
            bar_cnt <= '0;
            bar_pix <= '0;
        end else if (bar_pix == BPW'(BAR_W - 1)) begin
            bar_pix <= '0;
            if (bar_cnt != 3'd7) begin
                bar_cnt <= bar_cnt + 3'd1;
            end
        end else begin
            bar_pix <= bar_pix + BPW'(1);
        end
    end

    // The frame's first pixel already uses the mode sampled at frame start.
    always_comb begin
        pix_c      = RGB_BLACK;
        mode_eff_c = frame_start_c ? pat_e'(mode) : mode_q;
        if (active_c) begin
            case (mode_eff_c)
                PAT_BARS:   pix_c = BAR_COLORS[bar_cnt];
                PAT_RAMP:   pix_c = {8'(h), 8'(h), 8'(h)};
                PAT_CHECK:  pix_c = (h_col_c[0] ^ v_b4_c) ? RGB_WHITE : RGB_BLACK;
                PAT_SCROLL: pix_c = (h_col_c == 7'(frame_cnt)) ? RGB_WHITE : RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_red    <= '0;
            tx_green  <= '0;
            tx_blue   <= '0;
            tx_dv     <= 1'b0;
            tx_hs     <= 1'b0;
            tx_vs     <= 1'b0;
            frame_cnt <= '0;
            mode_q    <= PAT_BARS;
        end else begin
            tx_red   <= pix_c.red;
            tx_green <= pix_c.green;
            tx_blue  <= pix_c.blue;
            tx_dv    <= active_c;
            tx_hs    <= hs_c;
            tx_vs    <= vs_c;
            if (frame_start_c) begin
                mode_q <= pat_e'(mode);
            end
            if (frame_end_c) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_video_pattern_gen.sv
// Self-checking bench for video_pattern_gen on a 24x8 raster, compared
// against a pixel-index arithmetic model of the stream.
module tb_video_pattern_gen;

    localparam int H_ACT  = 16;
    localparam int H_FP   = 2;
    localparam int H_SYNC = 2;
    localparam int H_BP   = 4;
    localparam int V_ACT  = 4;
    localparam int V_FP   = 1;
    localparam int V_SYNC = 1;
    localparam int V_BP   = 2;
    localparam int HT     = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int VT     = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int FT     = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [7:0] tx_red, tx_green, tx_blue, frame_cnt;
    logic       tx_dv, tx_hs, tx_vs;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [1:0]  fmode [0:511];
    logic [23:0] bar_tab [0:7] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                   24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic [23:0] e_rgb;
    logic        e_dv, e_hs, e_vs;

    video_pattern_gen #(
        .H_ACTIVE (H_ACT), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACT), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .tx_red    (tx_red),
        .tx_green  (tx_green),
        .tx_blue   (tx_blue),
        .tx_dv     (tx_dv),
        .tx_hs     (tx_hs),
        .tx_vs     (tx_vs),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    // Pixel p (counted from reset release) of the ideal stream.
    function automatic void model(input int p, output logic [23:0] rgb,
                                  output logic dv, output logic hs, output logic vs);
        int h, v, f, bar;
        h   = p % HT;
        v   = (p / HT) % VT;
        f   = p / FT;
        dv  = (h < H_ACT) && (v < V_ACT);
        hs  = (h >= H_ACT + H_FP) && (h < H_ACT + H_FP + H_SYNC);
        vs  = (v >= V_ACT + V_FP) && (v < V_ACT + V_FP + V_SYNC);
        rgb = 24'h0;
        if (dv) begin
            case (fmode[f])
                2'd0: begin
                    bar = h / (H_ACT / 8);
                    if (bar > 7) bar = 7;
                    rgb = bar_tab[bar];
                end
                2'd1: rgb = {8'(h), 8'(h), 8'(h)};
                2'd2: rgb = (((h / 16) + (v / 16)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
                default: rgb = ((h / 16) % 128 == (f % 256) % 128) ? 24'hFFFFFF : 24'h0;
            endcase
        end
    endfunction

    // One clock: note the mode the DUT will latch if counters sit at frame start.
    task automatic step();
        if (cyc % FT == 0) fmode[cyc / FT] = mode;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        rst  = 1'b0;
        mode = 2'd0;
        repeat (2) @(negedge clk);
        checks++;
        if ({tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, frame_cnt} !== 35'h0) begin
            errors++;
            $display("FAIL reset_outputs got rgb=%h dv/hs/vs=%b%b%b fc=%0d want all 0",
                     {tx_red, tx_green, tx_blue}, tx_dv, tx_hs, tx_vs, frame_cnt);
        end
        release_reset();
    endtask

    task automatic test_raster();
        int dv_n = 0, hs_n = 0, vs_n = 0, dv_in_vs = 0;
        for (int i = 0; i < FT; i++) begin
            step();
            model(cyc - 1, e_rgb, e_dv, e_hs, e_vs);
            dv_n += int'(tx_dv);
            hs_n += int'(tx_hs);
            vs_n += int'(tx_vs);
            if (tx_vs && tx_dv) dv_in_vs++;
            if (cyc == 1) begin
                checks++;
                if (tx_dv !== 1'b1 || {tx_red, tx_green, tx_blue} !== 24'hFFFFFF) begin
                    errors++;
                    $display("FAIL first_pixel got dv=%b rgb=%h want dv=1 rgb=ffffff",
                             tx_dv, {tx_red, tx_green, tx_blue});
                end
            end
            checks++;
            if ({tx_red, tx_green, tx_blue} !== e_rgb) begin
                errors++;
                $display("FAIL raster_rgb cyc=%0d got %h want %h", cyc, {tx_red, tx_green, tx_blue}, e_rgb);
            end
            checks++;
            if ({tx_dv, tx_hs, tx_vs} !== {e_dv, e_hs, e_vs}) begin
                errors++;
                $display("FAIL raster_sync cyc=%0d got %b%b%b want %b%b%b",
                         cyc, tx_dv, tx_hs, tx_vs, e_dv, e_hs, e_vs);
            end
        end
        checks++;
        if (dv_n != 64 || hs_n != 16 || vs_n != 24 || dv_in_vs != 0) begin
            errors++;
            $display("FAIL frame_counts got dv=%0d hs=%0d vs=%0d dv_in_vs=%0d want 64 16 24 0",
                     dv_n, hs_n, vs_n, dv_in_vs);
        end
    endtask

    task automatic test_mode_switch();
        // Frame 1: switch to ramp on line 2; frames 3..6 get random mode changes.
        while (cyc < 7 * FT) begin
            if (cyc == FT + 2 * HT) mode = 2'd1;
            if (cyc >= 3 * FT && $urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
            step();
            model(cyc - 1, e_rgb, e_dv, e_hs, e_vs);
            if (cyc - 1 == 2 * FT + 15) begin
                checks++;
                if ({tx_red, tx_green, tx_blue} !== 24'h0F0F0F) begin
                    errors++;
                    $display("FAIL ramp_end got %h want 0f0f0f", {tx_red, tx_green, tx_blue});
                end
            end
            checks++;
            if ({tx_red, tx_green, tx_blue} !== e_rgb) begin
                errors++;
                $display("FAIL mode_rgb cyc=%0d got %h want %h", cyc, {tx_red, tx_green, tx_blue}, e_rgb);
            end
            checks++;
            if ({tx_dv, tx_hs, tx_vs} !== {e_dv, e_hs, e_vs}) begin
                errors++;
                $display("FAIL mode_sync cyc=%0d got %b%b%b want %b%b%b",
                         cyc, tx_dv, tx_hs, tx_vs, e_dv, e_hs, e_vs);
            end
        end
    endtask

    task automatic test_frame_wrap();
        mode = 2'd3;
        while (cyc < 258 * FT + 40) begin
            step();
            model(cyc - 1, e_rgb, e_dv, e_hs, e_vs);
            if (cyc == 256 * FT - 1 || cyc == 256 * FT) begin
                checks++;
                if (frame_cnt !== ((cyc == 256 * FT) ? 8'd0 : 8'd255)) begin
                    errors++;
                    $display("FAIL fc_wrap cyc=%0d got %0d", cyc, frame_cnt);
                end
            end
            checks++;
            if (frame_cnt !== 8'((cyc / FT) % 256)) begin
                errors++;
                $display("FAIL frame_cnt cyc=%0d got %0d want %0d", cyc, frame_cnt, (cyc / FT) % 256);
            end
            checks++;
            if ({tx_red, tx_green, tx_blue} !== e_rgb) begin
                errors++;
                $display("FAIL scroll_rgb cyc=%0d got %h want %h", cyc, {tx_red, tx_green, tx_blue}, e_rgb);
            end
        end
    endtask

    task automatic test_async_reset();
        while (cyc % FT != 2 * HT + 7) step();
        #1;
        rst  = 1'b0;
        mode = 2'd0;
        #1;
        checks++;
        if ({tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, frame_cnt} !== 35'h0) begin
            errors++;
            $display("FAIL async_reset got rgb=%h dv=%b fc=%0d want 0",
                     {tx_red, tx_green, tx_blue}, tx_dv, frame_cnt);
        end
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs, frame_cnt} !== 35'h0) begin
                errors++;
                $display("FAIL reset_hold got rgb=%h dv=%b fc=%0d want 0",
                         {tx_red, tx_green, tx_blue}, tx_dv, frame_cnt);
            end
        end
        release_reset();
        for (int i = 0; i < FT + 30; i++) begin
            step();
            model(cyc - 1, e_rgb, e_dv, e_hs, e_vs);
            checks++;
            if ({tx_red, tx_green, tx_blue, tx_dv, tx_hs, tx_vs} !== {e_rgb, e_dv, e_hs, e_vs}) begin
                errors++;
                $display("FAIL restart cyc=%0d got %h %b%b%b want %h %b%b%b", cyc,
                         {tx_red, tx_green, tx_blue}, tx_dv, tx_hs, tx_vs, e_rgb, e_dv, e_hs, e_vs);
            end
            checks++;
            if (frame_cnt !== 8'(cyc / FT)) begin
                errors++;
                $display("FAIL restart_fc cyc=%0d got %0d want %0d", cyc, frame_cnt, cyc / FT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_mode_switch();
        test_frame_wrap();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
